cyq_161_seq_ctrl: RTL

Sequencer for a cascade of 4-bit 74HC161 synchronous counters. It drives their PE/CEP/CET/D/MR pins so that the cascade acts as a programmable modulo-P period timer, using the synchronous-preset reload technique. It emits one tick per period, either for a fixed number of periods or free-running, and supports pause and abort. It sits between the lab top-level control logic and the counter datapath; the counter clocks share this block's `clk`.

---
 rtl/cyq_161_seq_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/cyq_161_seq_ctrl.sv
// rtl/cyq_161_seq_ctrl.sv - sequencer driving a 74HC161 cascade as a modulo-P period timer
// Reload value R = -period is preset on each terminal count so every period is exactly P cycles.
module cyq_161_seq_ctrl #(
  parameter int N_STAGES = 2,
  parameter int REP_W    = 4
) (
  input  logic                  i_clk,
  input  logic                  i_mr,
  input  logic                  i_start,
  input  logic                  i_stop,
  input  logic                  i_pause,
  input  logic [4*N_STAGES-1:0] i_period,
  input  logic [REP_W-1:0]      i_reps,
  input  logic                  i_cnt_tc,
  output logic                  o_cnt_clr_n,
  output logic                  o_cnt_pe_n,
  output logic                  o_cnt_cep,
  output logic                  o_cnt_cet,
  output logic [4*N_STAGES-1:0] o_cnt_d,
  output logic                  o_busy,
  output logic                  o_tick,
  output logic                  o_done,
  output logic [REP_W-1:0]      o_reps_left
);

  localparam int W = 4 * N_STAGES;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [W-1:0]     r_reload;
  logic [W-1:0]     w_reload_nxt;
  logic [REP_W-1:0] r_reps_left;
  logic [REP_W-1:0] w_reps_left_nxt;
  logic             r_free_run;
  logic             w_free_run_nxt;
  logic             w_tick;
  logic             w_last;

  always_ff @(posedge i_clk) begin
    if (i_mr) begin
      r_state     <= S_IDLE;
      r_reload    <= '0;
      r_reps_left <= '0;
      r_free_run  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_reload    <= w_reload_nxt;
      r_reps_left <= w_reps_left_nxt;
      r_free_run  <= w_free_run_nxt;
    end
  end

  // stop outranks both the tick and the completion of the run
  assign w_tick = (r_state == S_RUN) & i_cnt_tc & ~i_pause & ~i_stop;
  assign w_last = ~r_free_run & (r_reps_left == REP_W'(1));

  always_comb begin
    w_state_nxt     = r_state;
    w_reload_nxt    = r_reload;
    w_reps_left_nxt = r_reps_left;
    w_free_run_nxt  = r_free_run;
    o_cnt_clr_n     = 1'b0;
    o_cnt_pe_n      = 1'b1;
    o_cnt_cep       = 1'b0;
    o_cnt_cet       = 1'b0;
    o_cnt_d         = '0;
    o_busy          = 1'b0;
    o_done          = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_start && !i_stop) begin
          w_state_nxt     = S_LOAD;
          w_reload_nxt    = ~i_period + W'(1);
          w_reps_left_nxt = i_reps;
          w_free_run_nxt  = (i_reps == '0);
        end
      end
      S_LOAD: begin
        o_cnt_clr_n = 1'b1;
        o_cnt_pe_n  = 1'b0;
        o_cnt_d     = r_reload;
        o_busy      = 1'b1;
        w_state_nxt = S_RUN;
        if (i_stop) begin
          w_state_nxt     = S_IDLE;
          w_reps_left_nxt = '0;
        end
      end
      S_RUN: begin
        o_cnt_clr_n = 1'b1;
        o_cnt_d     = r_reload;
        o_cnt_cet   = 1'b1;
        o_cnt_cep   = ~i_pause;
        o_busy      = 1'b1;
        if (i_stop) begin
          w_state_nxt     = S_IDLE;
          w_reps_left_nxt = '0;
        end else if (w_tick) begin
          // final period lets the cascade wrap to 0 instead of reloading
          if (w_last) begin
            w_state_nxt     = S_DONE;
            w_reps_left_nxt = '0;
          end else begin
            o_cnt_pe_n = 1'b0;
            if (!r_free_run) w_reps_left_nxt = r_reps_left - REP_W'(1);
          end
        end
      end
      S_DONE: begin
        o_cnt_clr_n = 1'b1;
        o_cnt_d     = r_reload;
        o_busy      = 1'b1;
        o_done      = ~i_stop;
        w_state_nxt = S_IDLE;
        if (i_stop) w_reps_left_nxt = '0;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign o_tick      = w_tick;
  assign o_reps_left = r_reps_left;

endmodule
